// File: rtl/lbp_window_engine_if.sv
// Read/write handshake bundle between the LBP window engine and its frame and
// result memories.
interface lbp_window_engine_if #(
  parameter int AW    = 14,
  parameter int PIX_W = 8
);
  logic             gray_req;
  logic [AW-1:0]    gray_addr;
  logic             gray_ready;
  logic [PIX_W-1:0] gray_data;
  logic             lbp_valid;
  logic [AW-1:0]    lbp_addr;
  logic [7:0]       lbp_data;
  logic             lbp_ready;

  modport master (
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
    input  gray_ready, gray_data, lbp_ready
  );

  modport slave (
    input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
    output gray_ready, gray_data, lbp_ready
  );
endinterface

// File: rtl/lbp_window_engine.sv
// Raster-scan LBP engine: 3x3 sliding window over an external frame memory,
// one thresholded 8-neighbour code per pixel written to the result memory.
module lbp_window_engine #(
  parameter int LOG_W       = 7,
  parameter int LOG_H       = 7,
  parameter int PIX_W       = 8,
  parameter int BORDER_MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PIX_W-1:0]     thr,
  output logic                 finish,
  lbp_window_engine_if.master  bus
);
  localparam int AW = LOG_W + LOG_H;

  typedef enum logic [2:0] {
    S_IDLE, S_FULL_RD, S_SLIDE_RD, S_CALC, S_WR, S_SKIP, S_DONE
  } state_e;

  state_e           state_q;
  logic [AW-1:0]    p_q;
  logic [PIX_W-1:0] thr_q;
  logic [PIX_W-1:0] win_q [0:8];
  logic             win_valid_q;
  logic [1:0]       rd_row_q;
  logic [1:0]       rd_col_q;
  logic             cap_pend_q;
  logic [3:0]       cap_slot_q;
  logic             gray_req_q;
  logic [AW-1:0]    gray_addr_q;
  logic             lbp_valid_q;
  logic [AW-1:0]    lbp_addr_q;
  logic [7:0]       lbp_data_q;
  logic             finish_q;

  logic [AW-1:0]    pix_d;
  logic [LOG_W-1:0] nx_d;
  logic [LOG_H-1:0] ny_d;
  logic             nborder_d;
  logic             nslide_d;
  logic             last_d;
  logic             adv_d;
  logic [1:0]       nrow_d;
  logic [1:0]       ncol_d;
  logic [3:0]       slot_d;
  logic [PIX_W:0]   lim_d;
  logic [7:0]       code_d;

  // Address of window cell (row r, col c) around pixel p; rows/cols 0..2 map to -1..+1.
  function automatic logic [AW-1:0] rd_addr(input logic [AW-1:0] p, input logic [1:0] r,
                                            input logic [1:0] c);
    logic [LOG_H-1:0] y;
    logic [LOG_W-1:0] x;
    y = p[AW-1:LOG_W] + LOG_H'(r) - LOG_H'(1);
    x = p[LOG_W-1:0] + LOG_W'(c) - LOG_W'(1);
    return {y, x};
  endfunction

  function automatic logic ge_lim(input logic [PIX_W-1:0] n, input logic [PIX_W:0] lim);
    return ({1'b0, n} >= lim);
  endfunction

  // Classification of the pixel the engine moves to next, and read-walk stepping.
  always_comb begin
    if (state_q == S_WR || state_q == S_SKIP) begin
      pix_d = p_q + AW'(1);
    end else begin
      pix_d = {AW{1'b0}};
    end
    nx_d      = pix_d[LOG_W-1:0];
    ny_d      = pix_d[AW-1:LOG_W];
    nborder_d = (nx_d == {LOG_W{1'b0}}) || (nx_d == {LOG_W{1'b1}}) ||
                (ny_d == {LOG_H{1'b0}}) || (ny_d == {LOG_H{1'b1}});
    nslide_d  = win_valid_q && (state_q == S_WR || state_q == S_SKIP) && (nx_d >= LOG_W'(2));
    last_d    = (p_q == {AW{1'b1}});
    adv_d     = ((state_q == S_IDLE || state_q == S_DONE) && start) ||
                (state_q == S_WR && bus.lbp_ready && !last_d) ||
                (state_q == S_SKIP && !last_d);
    nrow_d = rd_row_q;
    ncol_d = rd_col_q;
    if (state_q == S_SLIDE_RD) begin
      nrow_d = rd_row_q + 2'd1;
      ncol_d = 2'd2;
    end else if (rd_col_q == 2'd2) begin
      nrow_d = rd_row_q + 2'd1;
      ncol_d = 2'd0;
    end else begin
      ncol_d = rd_col_q + 2'd1;
    end
    slot_d = 4'(rd_row_q) * 4'd3 + 4'(rd_col_q);
  end

  // Threshold compare at PIX_W+1 bits so centre+thr never wraps.
  always_comb begin
    lim_d     = {1'b0, win_q[4]} + {1'b0, thr_q};
    code_d[0] = ge_lim(win_q[0], lim_d);
    code_d[1] = ge_lim(win_q[1], lim_d);
    code_d[2] = ge_lim(win_q[2], lim_d);
    code_d[3] = ge_lim(win_q[3], lim_d);
    code_d[4] = ge_lim(win_q[5], lim_d);
    code_d[5] = ge_lim(win_q[6], lim_d);
    code_d[6] = ge_lim(win_q[7], lim_d);
    code_d[7] = ge_lim(win_q[8], lim_d);
  end

  // Control FSM, window capture and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      p_q         <= {AW{1'b0}};
      thr_q       <= {PIX_W{1'b0}};
      for (int i = 0; i < 9; i++) win_q[i] <= {PIX_W{1'b0}};
      win_valid_q <= 1'b0;
      rd_row_q    <= 2'd0;
      rd_col_q    <= 2'd0;
      cap_pend_q  <= 1'b0;
      cap_slot_q  <= 4'd0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= {AW{1'b0}};
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= {AW{1'b0}};
      lbp_data_q  <= 8'd0;
      finish_q    <= 1'b0;
    end else begin
      if (cap_pend_q) win_q[cap_slot_q] <= bus.gray_data;
      cap_pend_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            thr_q       <= thr;
            finish_q    <= 1'b0;
            win_valid_q <= 1'b0;
          end
        end
        S_FULL_RD, S_SLIDE_RD: begin
          if (gray_req_q && bus.gray_ready) begin
            cap_pend_q <= 1'b1;
            cap_slot_q <= slot_d;
            if (rd_row_q == 2'd2 && rd_col_q == 2'd2) begin
              gray_req_q <= 1'b0;
            end else begin
              rd_row_q    <= nrow_d;
              rd_col_q    <= ncol_d;
              gray_addr_q <= rd_addr(p_q, nrow_d, ncol_d);
            end
          end
          // Bottom-right cell is always the last one fetched in either read mode.
          if (cap_pend_q && cap_slot_q == 4'd8) begin
            state_q     <= S_CALC;
            win_valid_q <= 1'b1;
          end
        end
        S_CALC: begin
          lbp_data_q  <= code_d;
          lbp_addr_q  <= p_q;
          lbp_valid_q <= 1'b1;
          state_q     <= S_WR;
        end
        S_WR: begin
          if (bus.lbp_ready) begin
            lbp_valid_q <= 1'b0;
            if (last_d) begin
              state_q  <= S_DONE;
              finish_q <= 1'b1;
            end
          end
        end
        S_SKIP: begin
          if (last_d) begin
            state_q  <= S_DONE;
            finish_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (adv_d) begin
        p_q <= pix_d;
        if (nborder_d) begin
          win_valid_q <= 1'b0;
          if (BORDER_MODE == 0) begin
            state_q     <= S_WR;
            lbp_valid_q <= 1'b1;
            lbp_addr_q  <= pix_d;
            lbp_data_q  <= 8'd0;
          end else begin
            state_q <= S_SKIP;
          end
        end else if (nslide_d) begin
          win_q[0]    <= win_q[1];
          win_q[1]    <= win_q[2];
          win_q[3]    <= win_q[4];
          win_q[4]    <= win_q[5];
          win_q[6]    <= win_q[7];
          win_q[7]    <= win_q[8];
          state_q     <= S_SLIDE_RD;
          gray_req_q  <= 1'b1;
          rd_row_q    <= 2'd0;
          rd_col_q    <= 2'd2;
          gray_addr_q <= rd_addr(pix_d, 2'd0, 2'd2);
        end else begin
          state_q     <= S_FULL_RD;
          gray_req_q  <= 1'b1;
          rd_row_q    <= 2'd0;
          rd_col_q    <= 2'd0;
          gray_addr_q <= rd_addr(pix_d, 2'd0, 2'd0);
        end
      end
    end
  end

  assign bus.gray_req  = gray_req_q;
  assign bus.gray_addr = gray_addr_q;
  assign bus.lbp_valid = lbp_valid_q;
  assign bus.lbp_addr  = lbp_addr_q;
  assign bus.lbp_data  = lbp_data_q;
  assign finish        = finish_q;
endmodule

// File: tb/tb_lbp_window_engine.sv
// Directed bench for lbp_window_engine on 4x4 frames, both border modes.
module tb_lbp_window_engine;
  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [7:0] thr_v;
  logic       fin0, fin1;
  logic       bp_en = 1'b0;
  logic [7:0] mem [16];

  int vectors = 0;
  int miscompares = 0;

  lbp_window_engine_if #(.AW(4), .PIX_W(8)) b0 ();
  lbp_window_engine_if #(.AW(4), .PIX_W(8)) b1 ();

  lbp_window_engine #(.LOG_W(2), .LOG_H(2), .PIX_W(8), .BORDER_MODE(0)) dut0 (
    .clk(clk), .reset(rst), .start(start0), .thr(thr_v), .finish(fin0), .bus(b0));
  lbp_window_engine #(.LOG_W(2), .LOG_H(2), .PIX_W(8), .BORDER_MODE(1)) dut1 (
    .clk(clk), .reset(rst), .start(start1), .thr(thr_v), .finish(fin1), .bus(b1));

  always #5 clk = ~clk;

  always @(posedge clk) if (b0.gray_req && b0.gray_ready) b0.gray_data <= mem[b0.gray_addr];
  always @(posedge clk) if (b1.gray_req && b1.gray_ready) b1.gray_data <= mem[b1.gray_addr];

  initial begin
    b0.gray_ready = 1'b1; b0.lbp_ready = 1'b1;
    b1.gray_ready = 1'b1; b1.lbp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      b0.gray_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      b0.lbp_ready  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int         cyc = 0, wr_n = 0, acc_n = 0, rd_since = 0, wr1_n = 0;
  logic [3:0] wr_addr [64];
  logic [7:0] wr_data [64];
  int         wr_cyc  [64];
  int         rd_per  [16];
  logic [3:0] acc_log [256];
  logic [3:0] wr1_addr [64];
  logic [7:0] wr1_data [64];
  logic       p_gst = 1'b0, p_lst = 1'b0;
  logic [3:0] p_gaddr, p_laddr;
  logic [7:0] p_ldata;

  // Handshake logger plus hold and exclusivity checks on every cycle.
  always @(negedge clk) begin
    cyc++;
    if (p_gst) begin
      vectors++;
      assert (b0.gray_req === 1'b1 && b0.gray_addr === p_gaddr) else begin
        miscompares++;
        $error("FAIL gray_hold observed req=%0b addr=%0d expected req=1 addr=%0d",
               b0.gray_req, b0.gray_addr, p_gaddr);
      end
    end
    if (p_lst) begin
      vectors++;
      assert (b0.lbp_valid === 1'b1 && b0.lbp_addr === p_laddr && b0.lbp_data === p_ldata) else begin
        miscompares++;
        $error("FAIL lbp_hold observed v=%0b a=%0d d=%0h expected v=1 a=%0d d=%0h",
               b0.lbp_valid, b0.lbp_addr, b0.lbp_data, p_laddr, p_ldata);
      end
    end
    if (b0.gray_req || b0.lbp_valid) begin
      vectors++;
      assert (!(b0.gray_req && b0.lbp_valid)) else begin
        miscompares++;
        $error("FAIL exclusive observed req=%0b valid=%0b expected one-hot", b0.gray_req, b0.lbp_valid);
      end
    end
    if (b0.gray_req && b0.gray_ready) begin
      if (acc_n < 256) acc_log[acc_n] = b0.gray_addr;
      acc_n++;
      rd_since++;
    end
    if (b0.lbp_valid && b0.lbp_ready) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = b0.lbp_addr;
        wr_data[wr_n] = b0.lbp_data;
        wr_cyc[wr_n]  = cyc;
      end
      rd_per[b0.lbp_addr] = rd_since;
      rd_since = 0;
      wr_n++;
    end
    if (b1.lbp_valid && b1.lbp_ready) begin
      if (wr1_n < 64) begin
        wr1_addr[wr1_n] = b1.lbp_addr;
        wr1_data[wr1_n] = b1.lbp_data;
      end
      wr1_n++;
    end
    p_gst   = b0.gray_req && !b0.gray_ready && !rst;
    p_gaddr = b0.gray_addr;
    p_lst   = b0.lbp_valid && !b0.lbp_ready && !rst;
    p_laddr = b0.lbp_addr;
    p_ldata = b0.lbp_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_n = 0; acc_n = 0; rd_since = 0; wr1_n = 0;
    for (int i = 0; i < 16; i++) rd_per[i] = 0;
  endtask

  task automatic run0(input string tag, input logic [7:0] t, input bit mid_start);
    int i;
    clear_logs();
    thr_v = t;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (i = 0; i < 3000 && fin0 !== 1'b1; i++) begin
      start0 = mid_start && (i == 20);
      @(negedge clk);
    end
    start0 = 1'b0;
    chk({tag, " finish"}, 32'(fin0), 32'd1);
  endtask

  task automatic chk_frame0(input string tag, input logic [7:0] e [16]);
    chk({tag, " count"}, wr_n, 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
      chk($sformatf("%s code%0d", tag, i), 32'(wr_data[i]), 32'(e[i]));
    end
  endtask

  logic [7:0] e_flat [16], e_ramp [16], e_pat [16], e_zero [16];
  logic [7:0] pat [16];
  logic [3:0] ramp_acc [12];
  logic       found;
  int         n_w, n_a;

  initial begin
    pat = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd25, 8'd60, 8'd70,
            8'd5, 8'd15, 8'd35, 8'd80, 8'd1, 8'd2, 8'd3, 8'd4};
    ramp_acc = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd3, 4'd7, 4'd11};
    for (int i = 0; i < 16; i++) begin
      e_flat[i] = 8'h00; e_ramp[i] = 8'h00; e_pat[i] = 8'h00; e_zero[i] = 8'h00;
    end
    e_flat[5] = 8'hFF; e_flat[6] = 8'hFF; e_flat[9] = 8'hFF; e_flat[10] = 8'hFF;
    e_ramp[5] = 8'h94; e_ramp[6] = 8'h94; e_ramp[9] = 8'h94; e_ramp[10] = 8'h94;
    e_pat[5]  = 8'h9C; e_pat[6]  = 8'h90; e_pat[9]  = 8'h17; e_pat[10]  = 8'h16;

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; thr_v = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {13'd0, b0.gray_req, b0.gray_addr, b0.lbp_valid, b0.lbp_addr, b0.lbp_data, fin0},
        32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Flat frame, ideal handshakes, with per-pixel write spacing.
    for (int i = 0; i < 16; i++) mem[i] = 8'h40;
    run0("flat", 8'h00, 1'b0);
    chk_frame0("flat", e_flat);
    chk("flat full pixel cycles", wr_cyc[5] - wr_cyc[4], 32'd12);
    chk("flat slide pixel cycles", wr_cyc[6] - wr_cyc[5], 32'd6);
    chk("flat border pixel cycles", wr_cyc[7] - wr_cyc[6], 32'd1);

    // Horizontal ramp with a start pulse mid-frame that must be ignored.
    for (int i = 0; i < 16; i++) mem[i] = 8'(16 * (i % 4));
    run0("ramp", 8'h08, 1'b1);
    chk_frame0("ramp", e_ramp);
    chk("ramp reads px5", rd_per[5], 32'd9);
    chk("ramp reads px6", rd_per[6], 32'd3);
    chk("ramp reads px9", rd_per[9], 32'd9);
    chk("ramp reads px10", rd_per[10], 32'd3);
    chk("ramp total reads", acc_n, 32'd24);
    for (int i = 0; i < 12; i++) chk($sformatf("ramp read addr%0d", i), 32'(acc_log[i]), 32'(ramp_acc[i]));

    // Saturation: centre+thr exceeds the pixel range.
    for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
    mem[5] = 8'hF0;
    run0("sat", 8'h20, 1'b0);
    chk_frame0("sat", e_zero);

    // Bit-order pattern, first ideal then with random stalls on both sides.
    for (int i = 0; i < 16; i++) mem[i] = pat[i];
    run0("pat", 8'h00, 1'b0);
    chk_frame0("pat", e_pat);
    bp_en = 1'b1;
    run0("pat_bp", 8'h00, 1'b0);
    bp_en = 1'b0;
    @(negedge clk);
    chk_frame0("pat_bp", e_pat);

    // Border-skip variant writes only the interior.
    for (int i = 0; i < 16; i++) mem[i] = 8'h40;
    clear_logs();
    thr_v = 8'h00;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 3000 && fin1 !== 1'b1; i++) @(negedge clk);
    chk("skip finish", 32'(fin1), 32'd1);
    chk("skip count", wr1_n, 32'd4);
    chk("skip addr0", 32'(wr1_addr[0]), 32'd5);
    chk("skip addr1", 32'(wr1_addr[1]), 32'd6);
    chk("skip addr2", 32'(wr1_addr[2]), 32'd9);
    chk("skip addr3", 32'(wr1_addr[3]), 32'd10);
    for (int i = 0; i < 4; i++) chk($sformatf("skip code%0d", i), 32'(wr1_data[i]), 32'hFF);

    // Reset during the sliding reads of pixel 6, then a clean restart.
    clear_logs();
    thr_v = 8'h00;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (b0.gray_req === 1'b1 && b0.gray_addr === 4'd3) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach slide px6", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midframe reset outputs",
        {13'd0, b0.gray_req, b0.gray_addr, b0.lbp_valid, b0.lbp_addr, b0.lbp_data, fin0}, 32'd0);
    rst = 1'b0;
    n_w = wr_n;
    n_a = acc_n;
    repeat (20) @(negedge clk);
    chk("no writes after reset", wr_n, 32'(n_w));
    chk("no reads after reset", acc_n, 32'(n_a));
    chk("idle finish low", 32'(fin0), 32'd0);
    run0("restart", 8'h00, 1'b0);
    chk_frame0("restart", e_flat);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lbp_window_engine.md
# lbp_window_engine

Parametrised Local Binary Pattern engine that replaces the fixed 128x128, 8-bit, nine-reads-per-pixel LBP block. It scans a 2^LOG_W x 2^LOG_H grayscale frame held in an external single-port memory and computes a thresholded 8-neighbour LBP code for every pixel. Codes are written in raster order to the result memory. A 3x3 sliding window cuts interior reads from 9 to 3 per pixel, and both read and write sides are fully handshaked.

## Interface

**Parameters**
- LOG_W, 7, log2 of frame width.
- LOG_H, 7, log2 of frame height.
- PIX_W, 8, pixel bit width.
- BORDER_MODE, 0, border handling:
  - 0: border pixels are written with code 0.
  - 1: border pixels are skipped and never written.
- AW, LOG_W+LOG_H, address width (derived, not overridable).

**Ports** (name, direction, width, meaning)
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, one-cycle pulse; begins a frame when in IDLE or DONE.
- thr, in, PIX_W, comparison threshold; sampled on accepted start.
- gray_req, out, 1, read request.
- gray_addr, out, AW, read address; held stable while gray_req && !gray_ready.
- gray_ready, in, 1, memory accepts the request this cycle.
- gray_data, in, PIX_W, read data; valid exactly one cycle after acceptance.
- lbp_valid, out, 1, write request.
- lbp_addr, out, AW, write address equal to pixel index y*2^LOG_W+x.
- lbp_data, out, 8, LBP code.
- lbp_ready, in, 1, write accepted this cycle.
- finish, out, 1, high in DONE.

## Operation

**States:** IDLE, FULL_RD, SLIDE_RD, CALC, WR, SKIP, DONE.

**Start**
- IDLE/DONE –start→ set pixel index p = 0, latch thr, enter classify.
- start while busy is ignored.

**Classify** pixel (x, y)
- Border (x=0, x=2^LOG_W-1, y=0 or y=2^LOG_H-1): go to WR with code 0 (BORDER_MODE=0) or to SKIP (BORDER_MODE=1).
- Interior with valid window (previous pixel was interior in the same row, x ≥ 2): go to SLIDE_RD.
- Other interior: go to FULL_RD.

**Reads**
- FULL_RD issues 9 reads in order: rows y-1, y, y+1; within each row, columns x-1, x, x+1.
- SLIDE_RD shifts the window left one column, then issues 3 reads at column x+1 for rows y-1, y, y+1.
- One request per cycle. The address advances only on gray_ready. The returned datum is captured into its window slot one cycle after acceptance.
- After the last datum is captured, go to CALC.

**Calc** (1 cycle)
- With c = centre, bit k = (n_k ≥ c + thr), computed at PIX_W+1 bits with no wrap. Any thr > max−c gives 0 for that bit.
- Bit order: bit0 (-1,-1), bit1 (-1,0), bit2 (-1,+1), bit3 (0,-1), bit4 (0,+1), bit5 (+1,-1), bit6 (+1,0), bit7 (+1,+1), as (dy,dx).
- Register the code into lbp_data, then go to WR.

**WR**
- lbp_valid = 1; lbp_addr and lbp_data are held until lbp_ready.
- On lbp_ready: if p is the last pixel go to DONE, else increment p and classify.

**SKIP** (1 cycle)
- No write. Advance p like WR.

**Window validity**
- Cleared on every border pixel, at row change and at start.

**DONE**
- finish = 1 until start or reset.

## Timing

- **Reset values:** state IDLE; gray_req 0, gray_addr 0, lbp_valid 0, lbp_addr 0, lbp_data 0, finish 0; window and thr registers 0.
- **Reset mid-frame:** reset in any state returns to IDLE next edge. No further reads or writes for the aborted frame.
- **All outputs are registered.**
- **Ideal latency** (gray_ready = lbp_ready = 1):
  - FULL_RD pixel: 9 request cycles + 1 capture + 1 CALC; WR in cycle 11, so 12 cycles/pixel.
  - SLIDE_RD pixel: 3 + 1 + 1, WR in cycle 5, so 6 cycles/pixel.
  - Border: 1 cycle (WR or SKIP).
- **Stalls:**
  - gray_ready low inserts cycles with no state or address change.
  - lbp_ready low holds WR indefinitely.
- **Exclusivity:** gray_req and lbp_valid are never high in the same cycle.
- **Start to first request:** gray_req for the first non-border pixel rises no earlier than the cycle after classification.
- **Counter wrap:** p wraps never; DONE is entered from the last pixel 2^AW-1.

## Test plan

- **Flat frame:** LOG_W=LOG_H=2, all pixels 0x40, thr=0, BORDER_MODE=0.
  - Required: addresses 5, 6, 9, 10 get 0xFF; the other 12 get 0x00.
  - Required: 16 writes in raster order, finish after the last one.
- **Horizontal ramp:** pixel = 16·x, thr=8.
  - Required: interior code 0x94 (bits 2, 4, 7 only).
  - Required: 4th-column reads per interior pixel after the first of each row = 3 (count gray_ready acceptances: 9 then 3).
- **Threshold saturation:** centre 0xF0, neighbours 0xFF, thr=0x20.
  - Required: code 0x00 (no wrap).
- **Backpressure:** random gray_ready and lbp_ready at 50% duty.
  - Required: identical codes and addresses to the ideal run.
  - Required: gray_addr and lbp_data held stable while stalled.
- **BORDER_MODE=1, 4x4 frame.**
  - Required: exactly 4 writes, at addresses 5, 6, 9, 10.
- **Reset and restart:** assert reset during the SLIDE_RD of pixel 6.
  - Required: all outputs 0 next cycle.
  - Required: no writes until start, and a restarted frame matches the flat-frame result.
